// File: rtl/lsu_mem_responder.sv
// Data-memory side of the LSU handshake: one req/ack bus access per start, aligned/extended load data.
// Latency: done pulse one cycle after DM_ACK (cycle 1 on error/misalign); DM_REQ held until ACK or timeout.
module lsu_mem_responder #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        LSU_START,
   input  logic        MEM_WRITE_ENB,
   input  logic [2:0]  LSU_OPT,
   input  logic [31:0] ADDR,
   input  logic [31:0] WDATA,
   output logic        READ_READY,
   output logic        WRITE_DONE,
   output logic [31:0] LSU_RESULT,
   output logic        BUSY,
   output logic        MISALIGN,
   output logic        ERR,
   output logic        DM_REQ,
   output logic        DM_WE,
   output logic [31:0] DM_ADDR,
   output logic [3:0]  DM_BE,
   output logic [31:0] DM_WDATA,
   input  logic        DM_ACK,
   input  logic [31:0] DM_RDATA
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

   // Returns {legal, size} for a write-enable/opt pair.
   function automatic logic [2:0] decode(input logic we, input logic [2:0] opt);
      logic [2:0] d;
      d = {1'b0, SZ_B};
      case ({we, opt})
         4'b0000, 4'b0100: d = {1'b1, SZ_B};
         4'b0001, 4'b0101: d = {1'b1, SZ_H};
         4'b0010:          d = {1'b1, SZ_W};
         4'b1101:          d = {1'b1, SZ_B};
         4'b1110:          d = {1'b1, SZ_H};
         4'b1111:          d = {1'b1, SZ_W};
         default:          d = {1'b0, SZ_B};
      endcase
      return d;
   endfunction

   logic [1:0]  state;
   logic        we_q;
   logic        sext_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [7:0]  cnt;
   logic [7:0]  cnt_next;
   logic [31:0] result_q;
   logic        misalign_q;
   logic        err_q;

   logic [2:0]  in_dec;
   logic        in_legal;
   logic [1:0]  in_size;
   logic        in_mis;

   logic [31:0] rd_shift;
   logic [31:0] ld_data;
   logic [3:0]  be;
   logic [31:0] wd_rep;
   logic        in_access;

   assign in_dec   = decode(MEM_WRITE_ENB, LSU_OPT);
   assign in_legal = in_dec[2];
   assign in_size  = in_dec[1:0];
   assign in_mis   = in_legal && (((in_size == SZ_H) && ADDR[0]) ||
                                  ((in_size == SZ_W) && (ADDR[1:0] != 2'b00)));

   assign cnt_next = cnt + 8'd1;

   assign rd_shift = DM_RDATA >> {addr_q[1:0], 3'b000};

   always_comb begin
      ld_data = rd_shift;
      case (size_q)
         SZ_B:    ld_data = sext_q ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                   : {24'h0, rd_shift[7:0]};
         SZ_H:    ld_data = sext_q ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                   : {16'h0, rd_shift[15:0]};
         default: ld_data = rd_shift;
      endcase
   end

   always_comb begin
      be     = 4'b1111;
      wd_rep = wdata_q;
      case (size_q)
         SZ_B: begin
            be     = 4'b0001 << addr_q[1:0];
            wd_rep = {4{wdata_q[7:0]}};
         end
         SZ_H: begin
            be     = 4'b0011 << addr_q[1:0];
            wd_rep = {2{wdata_q[15:0]}};
         end
         default: begin
            be     = 4'b1111;
            wd_rep = wdata_q;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= S_IDLE;
         we_q       <= 1'b0;
         sext_q     <= 1'b0;
         size_q     <= SZ_B;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         cnt        <= 8'h0;
         result_q   <= 32'h0;
         misalign_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (LSU_START) begin
                  we_q       <= MEM_WRITE_ENB;
                  sext_q     <= ~LSU_OPT[2];
                  size_q     <= in_size;
                  addr_q     <= ADDR;
                  wdata_q    <= WDATA;
                  cnt        <= 8'h0;
                  result_q   <= 32'h0;
                  misalign_q <= in_mis;
                  err_q      <= ~in_legal;
                  state      <= (!in_legal || in_mis) ? S_DONE : S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (DM_ACK) begin
                  if (!we_q) begin
                     result_q <= ld_data;
                  end
                  state <= S_DONE;
               end else begin
                  cnt <= cnt_next;
                  // Abort once DM_REQ has been up for TIMEOUT_CYC cycles with no ACK.
                  if (cnt_next == TMO) begin
                     err_q <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Bus and status outputs decode straight from state so reset drops them without waiting for an edge.
   assign in_access  = (state == S_ACCESS);
   assign BUSY       = (state != S_IDLE);
   assign DM_REQ     = in_access;
   assign DM_WE      = in_access & we_q;
   assign DM_ADDR    = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
   assign DM_BE      = in_access ? be : 4'b0000;
   assign DM_WDATA   = (in_access && we_q) ? wd_rep : 32'h0;
   assign READ_READY = (state == S_DONE) & ~we_q;
   assign WRITE_DONE = (state == S_DONE) & we_q;
   assign LSU_RESULT = result_q;
   assign MISALIGN   = misalign_q;
   assign ERR        = err_q;

endmodule
